aes_enc128_iter: RTL and testbench
==================================

AES_ENC128_ITER -- requirements
Module: aes_enc128_iter

Interface
REQ-001 Parameters: none; the block is fixed to AES-128 (Nk=4, Nr=10).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  plaintext/key pair offered.
REQ-005 in_ready  out  1  block can accept a pair this cycle.
REQ-006 in_data  in  128 (aes_128)  plaintext; byte 0 = bits [127:120], FIPS-197 column-major order.
REQ-007 in_key  in  128 (aes_128)  cipher key, same byte order.
REQ-008 out_valid  out  1  ciphertext available.
REQ-009 out_ready  in  1  consumer accepts ciphertext this cycle.
REQ-010 out_data  out  128 (aes_128)  ciphertext, same byte order.
REQ-011 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-012 FSM states IDLE, ROUND, DONE; one block in flight at a time; no pipelining of multiple blocks.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, the block registers st <= in_data XOR in_key, rk <= in_key, rnd <= 1, rcon <= 8'h01, and moves to ROUND.
REQ-014 in_data/in_key are sampled only at the accepting edge; later changes are ignored.
REQ-015 ROUND: one full round per cycle. Each cycle: rk' = key expansion of rk with rcon, st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk'), rk <= rk', rcon <= xtime(rcon), rnd <= rnd+1.
REQ-016 When rnd==10, MixColumns is omitted, and the FSM moves to DONE at that edge.
REQ-017 Key expansion: w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w5=w4^w1; w6=w5^w2; w7=w6^w3.
REQ-018 Rcon sequence generated by xtime SHALL be 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
REQ-019 SubBytes/SubWord use the composite-field S-box: isomorph, then GF((2^4)^2) inversion built from square_nibble, mul_lambda, invert_nibble and GF(2^4) multiply (mul_gf2/mul_phi), then inv_isomorph, then affine; 20 S-box instances (16 state, 4 key); input 00 maps to 63.
REQ-020 ShiftRows uses the package shift_rows function; MixColumns uses xtime, with each column computed as {02 03 01 01} circulant.
REQ-021 DONE: out_valid=1, out_data=st, in_ready=0; on out_ready go IDLE; out_data and out_valid SHALL stay stable while out_ready=0 (no timeout).
REQ-022 Latency: the pair is accepted at edge T and out_valid is high in the cycle after edge T+10, i.e. 10 cycles after acceptance.
REQ-023 Throughput: with out_ready held at 1, the next acceptance occurs no earlier than edge T+12.
REQ-024 in_valid asserted during ROUND/DONE is ignored (in_ready=0), and the offered pair is not consumed.
REQ-025 out_ready asserted outside DONE has no effect.
REQ-026 out_data SHALL be driven from the st register (no combinational path from inputs to out_data).

Reset
REQ-027 rst_n=0 at any edge, including mid-ROUND or in DONE, forces IDLE, st=0, rk=0, rnd=0, rcon=8'h01.
REQ-028 During and after reset: out_valid=0, out_data=128'h0, busy=0; in_ready=1 from the first cycle after rst_n returns high.
REQ-029 A block aborted by reset is lost; no partial output appears.

Verification
REQ-030 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after acceptance.
REQ-031 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; internal rk after round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 Back-pressure: all-zero key/pt with out_ready=0 for 20 cycles -> out_data holds 66e94bd4ef8a2c3b884cfa59ca342b2e stable with out_valid=1, in_ready=0; then a one-cycle out_ready pulse -> IDLE next cycle.
REQ-033 Reset mid-operation: rst_n low for 1 cycle at round 5 -> next cycle busy=0, in_ready=1, out_valid=0, out_data=0; a fresh C.1 vector then produces the correct ciphertext.
REQ-034 Ignored input: in_valid held high with changing data during ROUND -> result matches only the pair accepted at the IDLE edge; back-to-back blocks with out_ready=1 are accepted every 12 cycles.

Source files
------------

// File: rtl/aes_enc128_iter_if.sv
// Handshake bundle for the iterative AES-128 encryptor: plaintext/key in, ciphertext out.
interface aes_enc128_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_enc128_iter.sv
// Iterative AES-128 encryptor: one full round per cycle, composite-field S-boxes,
// on-the-fly key expansion, one block in flight.
package aes_enc128_iter_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [1:0] mul_gf2(input logic [1:0] q, input logic [1:0] w);
    return {(q[1] & w[1]) ^ (q[0] & w[1]) ^ (q[1] & w[0]),
            (q[1] & w[1]) ^ (q[0] & w[0])};
  endfunction

  function automatic logic [1:0] mul_phi(input logic [1:0] q);
    return {q[1] ^ q[0], q[1]};
  endfunction

  function automatic logic [3:0] mul_gf4(input logic [3:0] q, input logic [3:0] w);
    logic [1:0] hh;
    hh = mul_gf2(q[3:2], w[3:2]);
    return {hh ^ mul_gf2(q[3:2], w[1:0]) ^ mul_gf2(q[1:0], w[3:2]),
            mul_phi(hh) ^ mul_gf2(q[1:0], w[1:0])};
  endfunction

  function automatic logic [3:0] square_nibble(input logic [3:0] q);
    return {q[3], q[3] ^ q[2], q[2] ^ q[1], q[3] ^ q[1] ^ q[0]};
  endfunction

  function automatic logic [3:0] mul_lambda(input logic [3:0] q);
    return {q[2] ^ q[0], q[3] ^ q[2] ^ q[1] ^ q[0], q[3], q[2]};
  endfunction

  function automatic logic [3:0] invert_nibble(input logic [3:0] q);
    logic [3:0] k;
    k[3] = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[0]) ^ q[2];
    k[2] = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[0]) ^ q[2] ^ (q[2] & q[1]);
    k[1] = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[1] & q[0]) ^ q[2] ^ (q[2] & q[0]) ^ q[1];
    k[0] = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[1]) ^ (q[3] & q[1] & q[0])
         ^ (q[3] & q[0]) ^ q[2] ^ (q[2] & q[1]) ^ (q[2] & q[1] & q[0]) ^ q[1] ^ q[0];
    return k;
  endfunction

  function automatic logic [7:0] isomorph(input logic [7:0] q);
    logic [7:0] k;
    k[7] = q[7] ^ q[5];
    k[6] = q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    k[5] = q[7] ^ q[5] ^ q[3] ^ q[2];
    k[4] = q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1];
    k[3] = q[7] ^ q[6] ^ q[2] ^ q[1];
    k[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    k[1] = q[6] ^ q[4] ^ q[1];
    k[0] = q[6] ^ q[1] ^ q[0];
    return k;
  endfunction

  function automatic logic [7:0] inv_isomorph(input logic [7:0] q);
    logic [7:0] k;
    k[7] = q[7] ^ q[6] ^ q[5] ^ q[1];
    k[6] = q[6] ^ q[2];
    k[5] = q[6] ^ q[5] ^ q[1];
    k[4] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1];
    k[3] = q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    k[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    k[1] = q[5] ^ q[4];
    k[0] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0];
    return k;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  // Inversion of ah*y + al over GF((2^4)^2) with y^2 = y + lambda.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [3:0] ah, al, dinv;
    t    = isomorph(a);
    ah   = t[7:4];
    al   = t[3:0];
    dinv = invert_nibble(mul_lambda(square_nibble(ah)) ^ mul_gf4(ah ^ al, al));
    return affine(inv_isomorph({mul_gf4(ah, dinv), mul_gf4(ah ^ al, dinv)}));
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   b0, b1, b2, b3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      b0 = s[127-32*c -: 8];
      b1 = s[119-32*c -: 8];
      b2 = s[111-32*c -: 8];
      b3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
      o[119-32*c -: 8] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
      o[111-32*c -: 8] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
      o[103-32*c -: 8] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
    end
    return o;
  endfunction

endpackage

module aes_enc128_iter_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  assign s_o = aes_enc128_iter_pkg::sbox(a_i);
endmodule

module aes_enc128_iter (
  input logic            clk,
  input logic            rst_n,
  aes_enc128_iter_if.slave bus
);
  import aes_enc128_iter_pkg::*;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d, rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] sb, sr, rk_next, round_out;
  logic [31:0]  ksub, w4, w5, w6, w7;
  logic         in_ready, out_valid;

  for (genvar gi = 0; gi < 16; gi++) begin : g_state_sbox
    aes_enc128_iter_sbox u_sbox (.a_i(st_q[gi*8 +: 8]), .s_o(sb[gi*8 +: 8]));
  end

  for (genvar gk = 0; gk < 4; gk++) begin : g_key_sbox
    aes_enc128_iter_sbox u_sbox (.a_i(rk_q[gk*8 +: 8]), .s_o(ksub[gk*8 +: 8]));
  end

  // ksub is SubWord(w3) in place; the byte rotation applies afterwards.
  assign w4 = rk_q[127:96] ^ {ksub[23:0], ksub[31:24]} ^ {rcon_q, 24'h0};
  assign w5 = w4 ^ rk_q[95:64];
  assign w6 = w5 ^ rk_q[63:32];
  assign w7 = w6 ^ rk_q[31:0];
  assign rk_next = {w4, w5, w6, w7};

  assign sr        = shift_rows(sb);
  assign round_out = ((rnd_q == 4'd10) ? sr : mix_columns(sr)) ^ rk_next;

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    rk_d      = rk_q;
    rnd_d     = rnd_q;
    rcon_d    = rcon_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          st_d    = bus.in_data ^ bus.in_key;
          rk_d    = bus.in_key;
          rnd_d   = 4'd1;
          rcon_d  = 8'h01;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d   = round_out;
        rk_d   = rk_next;
        rcon_d = xtime(rcon_q);
        rnd_d  = rnd_q + 4'd1;
        if (rnd_q == 4'd10) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = st_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_enc128_iter.sv
// Self-checking bench: byte-array AES reference plus a cycle-level handshake model.
module tb_aes_enc128_iter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_enc128_iter_if bus ();
  aes_enc128_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference S-box built from brute-force GF(2^8) inversion.
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] model_aes(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            s[r+4*c] = gmul(8'h02, t[r+4*c]) ^ gmul(8'h03, t[(r+1)%4+4*c])
                     ^ t[(r+2)%4+4*c] ^ t[(r+3)%4+4*c];
          else
            s[r+4*c] = t[r+4*c];
          s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
        end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Cycle-level expectation: a pair accepted in idle appears 10 edges later and
  // is held until out_ready; reset clears everything.
  bit           m_known = 1'b0;
  bit           m_done  = 1'b0;
  bit           m_clear = 1'b0;
  int           m_left  = 0;
  logic [127:0] m_exp   = '0;
  int           cyc     = 0;
  int           acc_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_known <= 1'b1;
      m_left  <= 0;
      m_done  <= 1'b0;
      m_clear <= 1'b1;
    end else if (m_done) begin
      if (bus.out_ready) m_done <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (bus.in_valid) begin
      m_left  <= 10;
      m_exp   <= model_aes(bus.in_data, bus.in_key);
      m_clear <= 1'b0;
      acc_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("in_ready", {127'h0, bus.in_ready}, {127'h0, (m_left == 0 && !m_done)});
      chk("busy", {127'h0, bus.busy}, {127'h0, (m_left != 0 || m_done)});
      chk("out_valid", {127'h0, bus.out_valid}, {127'h0, m_done});
      if (m_done) chk("out_data", bus.out_data, m_exp);
      else if (m_clear) chk("out_data_clear", bus.out_data, '0);
    end
  end

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", {127'h0, bus.in_ready}, {127'h0, 1'b1});
    bus.in_valid = 1'b1;
    bus.in_data  = pt;
    bus.in_key   = key;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"}, {127'h0, bus.busy}, '0);
    chk({name, "_in_ready"}, {127'h0, bus.in_ready}, {127'h0, 1'b1});
    chk({name, "_out_valid"}, {127'h0, bus.out_valid}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n0, k;
    logic [127:0] pt2, key2;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    build_sbox();

    chk("model_c1", model_aes(C1_PT, C1_KEY), C1_CT);
    chk("model_b", model_aes(B_PT, B_KEY), B_CT);
    chk("model_zero", model_aes('0, '0), Z_CT);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_valid", {127'h0, bus.out_valid}, '0);
    chk("rst_busy", {127'h0, bus.busy}, '0);
    rst_n = 1'b1;
    chk("rst_in_ready", {127'h0, bus.in_ready}, {127'h0, 1'b1});

    send(C1_PT, C1_KEY);
    wait_done(lat);
    chk("c1_latency", lat, 10);
    chk("c1_ct", bus.out_data, C1_CT);
    drain();
    chk_idle("c1_after");

    send(B_PT, B_KEY);
    wait_done(lat);
    chk("b_latency", lat, 10);
    chk("b_ct", bus.out_data, B_CT);
    chk("b_rk10", dut.rk_q, B_RK10);
    drain();

    send('0, '0);
    wait_done(lat);
    for (int i = 0; i < 20; i++) begin
      chk("bp_data", bus.out_data, Z_CT);
      chk("bp_valid", {127'h0, bus.out_valid}, {127'h0, 1'b1});
      chk("bp_in_ready", {127'h0, bus.in_ready}, '0);
      @(posedge clk); #1;
    end
    drain();
    chk_idle("bp_after");

    send(C1_PT, C1_KEY);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_idle("midrst");
    chk("midrst_data", bus.out_data, '0);
    send(C1_PT, C1_KEY);
    wait_done(lat);
    chk("midrst_ct", bus.out_data, C1_CT);
    drain();

    pt2  = B_PT;
    key2 = C1_KEY;
    send(pt2, key2);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    chk("ignore_ct", bus.out_data, model_aes(pt2, key2));
    drain();

    n0 = acc_q.size();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = C1_PT;
    bus.in_key    = C1_KEY;
    k = 0;
    while (acc_q.size() < n0 + 3 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("b2b_count", (acc_q.size() >= n0 + 3), 1);
    if (acc_q.size() >= n0 + 3) begin
      chk("b2b_gap1", acc_q[n0+1] - acc_q[n0], 12);
      chk("b2b_gap2", acc_q[n0+2] - acc_q[n0+1], 12);
    end
    chk_idle("b2b_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
